// File: rtl/csi2_pkt_handler_if.sv
// Word-level bus between the CSI-2 header ECC decoder, the packet handler and the
// payload stream consumer.
interface csi2_pkt_handler_if #(
  parameter int VC_W = 2
) ();
  logic            valid_i;
  logic [31:0]     data_i;
  logic            error_i;
  logic            error_corrected_i;
  logic            pkt_done_i;
  logic [31:0]     tdata_o;
  logic [3:0]      tkeep_o;
  logic            tvalid_o;
  logic            tlast_o;
  logic            tuser_o;
  logic [VC_W-1:0] vc_o;
  logic [5:0]      dt_o;
  logic            frame_start_o;
  logic            frame_end_o;
  logic            hdr_err_o;
  logic            trunc_err_o;

  modport slave (
    input  valid_i, data_i, error_i, error_corrected_i, pkt_done_i,
    output tdata_o, tkeep_o, tvalid_o, tlast_o, tuser_o, vc_o, dt_o,
           frame_start_o, frame_end_o, hdr_err_o, trunc_err_o
  );

  modport master (
    output valid_i, data_i, error_i, error_corrected_i, pkt_done_i,
    input  tdata_o, tkeep_o, tvalid_o, tlast_o, tuser_o, vc_o, dt_o,
           frame_start_o, frame_end_o, hdr_err_o, trunc_err_o
  );
endinterface

// File: rtl/csi2_pkt_handler.sv
// CSI-2 packet handler: parses ECC-checked headers, strips header/CRC and streams long-packet payload.
// Define CSI2_PKT_STATS_EN to add the packet/ECC statistics counters and stats_clr_i.
//
// state     | meaning
// S_IDLE    | waiting for a header (or for pkt_done after a short packet)
// S_PAYLOAD | streaming long-packet payload words
// S_CRC     | payload complete, discarding CRC footer until pkt_done
// S_DROP    | header uncorrectable, discarding packet until pkt_done
module csi2_pkt_handler #(
  parameter int         VC_W         = 2,
  parameter int         WC_W         = 16,
  parameter logic [5:0] SHORT_DT_MAX = 6'h0F
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  csi2_pkt_handler_if.slave     bus
`ifdef CSI2_PKT_STATS_EN
  ,
  input  logic                  stats_clr_i,
  output logic [15:0]           long_pkt_cnt_o,
  output logic [15:0]           short_pkt_cnt_o,
  output logic [15:0]           ecc_corr_cnt_o,
  output logic [15:0]           ecc_err_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CRC, S_DROP} state_t;

  state_t          r_state;
  logic [WC_W-1:0] r_remaining;
  logic            r_sof_pending;
  logic            r_wait_done;
  logic [31:0]     r_tdata;
  logic [3:0]      r_tkeep;
  logic            r_tvalid;
  logic            r_tlast;
  logic            r_tuser;
  logic [VC_W-1:0] r_vc;
  logic [5:0]      r_dt;
  logic            r_frame_start;
  logic            r_frame_end;
  logic            r_hdr_err;
  logic            r_trunc_err;

  logic [5:0]      w_dt;
  logic [VC_W-1:0] w_vc;
  logic [WC_W-1:0] w_wc;
  logic            w_hdr_take;
  logic            w_hdr_drop;
  logic            w_is_short;
  logic [3:0]      w_last_keep;

  assign w_dt       = bus.data_i[5:0];
  assign w_vc       = bus.data_i[6 +: VC_W];
  assign w_wc       = bus.data_i[8 +: WC_W];
  // r_wait_done masks trailing words of a short packet while remaining in S_IDLE
  assign w_hdr_take = bus.valid_i && !bus.pkt_done_i && (r_state == S_IDLE) && !r_wait_done;
  assign w_hdr_drop = bus.error_i && !bus.error_corrected_i;
  assign w_is_short = (w_dt <= SHORT_DT_MAX);

  always_comb begin
    w_last_keep = 4'hF;
    case (r_remaining)
      WC_W'(1): w_last_keep = 4'h1;
      WC_W'(2): w_last_keep = 4'h3;
      WC_W'(3): w_last_keep = 4'h7;
      default:  w_last_keep = 4'hF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= S_IDLE;
      r_remaining   <= '0;
      r_sof_pending <= 1'b0;
      r_wait_done   <= 1'b0;
      r_tdata       <= '0;
      r_tkeep       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_tuser       <= 1'b0;
      r_vc          <= '0;
      r_dt          <= '0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_hdr_err     <= 1'b0;
      r_trunc_err   <= 1'b0;
    end else begin
      r_tvalid      <= 1'b0;
      r_tkeep       <= '0;
      r_tlast       <= 1'b0;
      r_tuser       <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_hdr_err     <= 1'b0;
      r_trunc_err   <= 1'b0;
      if (bus.pkt_done_i) begin
        if (r_state == S_PAYLOAD && r_remaining != '0)
          r_trunc_err <= 1'b1;
        r_state     <= S_IDLE;
        r_wait_done <= 1'b0;
      end else if (w_hdr_take) begin
        if (w_hdr_drop) begin
          r_hdr_err <= 1'b1;
          r_state   <= S_DROP;
        end else begin
          r_vc <= w_vc;
          r_dt <= w_dt;
          if (w_is_short) begin
            r_wait_done <= 1'b1;
            if (w_dt == 6'h00) begin
              r_frame_start <= 1'b1;
              r_sof_pending <= 1'b1;
            end
            if (w_dt == 6'h01)
              r_frame_end <= 1'b1;
          end else begin
            r_remaining <= w_wc;
            r_state     <= (w_wc == '0) ? S_CRC : S_PAYLOAD;
          end
        end
      end else if (bus.valid_i && r_state == S_PAYLOAD) begin
        r_tvalid      <= 1'b1;
        r_tdata       <= bus.data_i;
        r_tuser       <= r_sof_pending;
        r_sof_pending <= 1'b0;
        if (r_remaining > WC_W'(4)) begin
          r_tkeep     <= 4'hF;
          r_remaining <= r_remaining - WC_W'(4);
        end else begin
          r_tkeep     <= w_last_keep;
          r_tlast     <= 1'b1;
          r_remaining <= '0;
          r_state     <= S_CRC;
        end
      end
    end
  end

  assign bus.tdata_o       = r_tdata;
  assign bus.tkeep_o       = r_tkeep;
  assign bus.tvalid_o      = r_tvalid;
  assign bus.tlast_o       = r_tlast;
  assign bus.tuser_o       = r_tuser;
  assign bus.vc_o          = r_vc;
  assign bus.dt_o          = r_dt;
  assign bus.frame_start_o = r_frame_start;
  assign bus.frame_end_o   = r_frame_end;
  assign bus.hdr_err_o     = r_hdr_err;
  assign bus.trunc_err_o   = r_trunc_err;

`ifdef CSI2_PKT_STATS_EN
  // index: 0 long, 1 short, 2 corrected, 3 dropped
  logic [3:0][15:0] r_cnt;
  logic [3:0]       w_inc;

  assign w_inc[0] = w_hdr_take && !w_hdr_drop && !w_is_short;
  assign w_inc[1] = w_hdr_take && !w_hdr_drop &&  w_is_short;
  assign w_inc[2] = w_hdr_take && bus.error_i && bus.error_corrected_i;
  assign w_inc[3] = w_hdr_take && w_hdr_drop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (stats_clr_i) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (w_inc[i] && r_cnt[i] != 16'hFFFF)
          r_cnt[i] <= r_cnt[i] + 16'd1;
    end
  end

  assign long_pkt_cnt_o  = r_cnt[0];
  assign short_pkt_cnt_o = r_cnt[1];
  assign ecc_corr_cnt_o  = r_cnt[2];
  assign ecc_err_cnt_o   = r_cnt[3];
`endif

endmodule
